// File: rtl/npc_mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, counter width
// and the address-error predicate.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    // Wide enough to hold LATENCY-1 for LATENCY up to 15.
    localparam int CNT_W = 4;

    // An address is bad when it is not word aligned or when any bit above the
    // word-index field is set. The caller zero-extends its address to 64 bits.
    function automatic logic addr_err(input logic [63:0] addr, input int unsigned mem_aw);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ((addr >> (mem_aw + 2)) != 64'd0);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Byte-writable word storage: synchronous masked write, asynchronous read.
// Contents are deliberately not reset.
module sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [MEM_AW-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** MEM_AW;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask[i]) begin
                    mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sram_responder.sv
// Fixed-latency memory responder: accepts one request at a time, waits
// LATENCY cycles, performs the access, then holds the response until taken.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender keeps valid and payload stable until that edge, and the
// receiver's ready never depends combinationally on the sender's valid.
module sram_responder
    import npc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_addr,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output mem_state_e              dbg_state
);

    localparam int NB = DATA_WIDTH / 8;

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  access_err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign access_err = addr_err(64'(addr_q), MEM_AW);

    sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_AW     (MEM_AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q[MEM_AW+1:2]),
        .wdata (wdata_q),
        .wmask (wmask_q),
        .rdata (mem_rdata)
    );

    // Next-state, request latch, access and response register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        req_ready = (state_q == MEM_IDLE) && !rst;

        unique case (state_q)
            MEM_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Access edge; a reset here drops the write entirely.
                    mem_we  = wen_q && !access_err && !rst;
                    rdata_d = (wen_q || access_err) ? '0 : mem_rdata;
                    err_d   = access_err;
                    state_d = MEM_RESP;
                end
            end
            MEM_RESP: begin
                if (resp_ready) begin
                    state_d = MEM_IDLE;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // State, counter, request latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == MEM_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: four instances at LATENCY 2, 1, 15 and 4.
module tb_sram_responder;
    import npc_mem_pkg::*;

    localparam int NDUT = 4;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 15 : 4;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst        [NDUT];
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic [31:0] req_addr   [NDUT];
    logic        req_wen    [NDUT];
    logic [31:0] req_wdata  [NDUT];
    logic [3:0]  req_wmask  [NDUT];
    logic        resp_valid [NDUT];
    logic        resp_ready [NDUT];
    logic [31:0] resp_rdata [NDUT];
    logic        resp_err   [NDUT];
    mem_state_e  dbg_state  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sram_responder #(
            .DATA_WIDTH (32),
            .MEM_AW     (10),
            .LATENCY    ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 15 : 4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_wen    (req_wen[g]),
            .req_wdata  (req_wdata[g]),
            .req_wmask  (req_wmask[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .dbg_state  (dbg_state[g])
        );
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- driver tasks ----------------
    // Present a request and return just after its acceptance edge.
    task automatic issue(input int k, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic rready, output int acc);
        int n;
        req_valid[k]  = 1'b1;
        req_wen[k]    = wen;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        req_wmask[k]  = mask;
        resp_ready[k] = rready;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready[k] !== 1'b1 && n < 50);
        if (req_ready[k] !== 1'b1) timeout_fail("req_accept");
        acc = cyc;
        @(posedge clk);
        #1;
        // Scramble request inputs while they must be ignored.
        req_valid[k] = 1'b0;
        req_wen[k]   = ~wen;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_wmask[k] = 4'($urandom_range(0, 15));
    endtask

    // Full transaction; resp_ready is withheld for 'hold' cycles of response.
    task automatic txn(input int k, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask, input int hold,
                       output logic [31:0] rd, output logic er, output int lat, output int acc);
        issue(k, wen, addr, wdata, mask, (hold == 0), acc);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid[k] !== 1'b1 && lat < 50);
        if (resp_valid[k] !== 1'b1) timeout_fail("resp_wait");
        rd = resp_rdata[k];
        er = resp_err[k];
        for (int h = 0; h < hold; h++) begin
            check("bp_valid",     32'(resp_valid[k]), 32'd1);
            check("bp_rdata",     resp_rdata[k], rd);
            check("bp_err",       32'(resp_err[k]), 32'(er));
            check("bp_req_ready", 32'(req_ready[k]), 32'd0);
            @(negedge clk);
        end
        resp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[k] = 1'b0;
    endtask

    // ---------------- directed vector table (DUT 0, LATENCY 2) ----------------
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd, rd2;
        logic        er;
        int          lat, lat2, acc, acc2;

        for (int k = 0; k < NDUT; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = '0; req_wen[k] = 1'b0;
            req_wdata[k] = '0; req_wmask[k] = '0; resp_ready[k] = 1'b0;
        end

        vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0080, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0080, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0042, 32'h0,         4'hF, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b1, 32'h8000_0040, 32'h0BAD_0BAD, 4'hF, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0044, 32'h0000_0000, 4'hF, 32'h0,         1'b0};
        vecs[14] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'hA, 32'h0,         1'b0};
        vecs[15] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'h1200_5600, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0083, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  32'(req_ready[0]),  32'd0);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata",      resp_rdata[0],      32'd0);
        check("rst_err",        32'(resp_err[0]),   32'd0);
        check("rst_state",      32'(dbg_state[0]),  32'(MEM_IDLE));
        for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready[0]), 32'd1);

        // Table-driven vectors on DUT 0.
        for (int i = 0; i < NV; i++) begin
            txn(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, 0, rd, er, lat, acc);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(lat_of(0) + 1));
        end
        txn(0, 1'b0, 32'h80, 32'h0, 4'h0, 0, rd, er, lat, acc);
        check("err_write_no_effect", rd, 32'h11BB_33DD);

        // Back-pressure: 5 cycles of withheld resp_ready on a read of 0x40.
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 5, rd, er, lat, acc);
        check("bp_rdata_final", rd, 32'hDEAD_BEEF);
        check("bp_post_hs_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        check("bp_idle_req_ready", 32'(req_ready[0]), 32'd1);
        check("bp_idle_state", 32'(dbg_state[0]), 32'(MEM_IDLE));

        // Latency sweep with back-to-back requests on DUT 1 and DUT 2.
        for (int k = 1; k <= 2; k++) begin
            txn(k, 1'b1, 32'h100, 32'h0F0F_0000 + 32'(k), 4'hF, 0, rd, er, lat, acc);
            txn(k, 1'b0, 32'h100, 32'h0, 4'h0, 0, rd2, er, lat2, acc2);
            check($sformatf("sweep%0d_wr_lat", k), 32'(lat), 32'(lat_of(k) + 1));
            check($sformatf("sweep%0d_rd_lat", k), 32'(lat2), 32'(lat_of(k) + 1));
            check($sformatf("sweep%0d_turn", k), 32'(acc2 - acc), 32'(lat_of(k) + 2));
            check($sformatf("sweep%0d_rdata", k), rd2, 32'h0F0F_0000 + 32'(k));
        end

        // Reset during WAIT of a write on DUT 3 (LATENCY 4).
        txn(3, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 0, rd, er, lat, acc);
        issue(3, 1'b1, 32'h10, 32'h0000_0055, 4'hF, 1'b1, acc);
        @(negedge clk);
        rst[3] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rstw_req_ready", 32'(req_ready[3]), 32'd0);
            check("rstw_resp_valid", 32'(resp_valid[3]), 32'd0);
        end
        rst[3] = 1'b0;
        @(negedge clk);
        check("rstw_ready_after", 32'(req_ready[3]), 32'd1);
        txn(3, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, acc);
        check("rstw_mem_kept", rd, 32'hA5A5_A5A5);

        // Reset after the access edge: the write must already be in memory.
        issue(3, 1'b1, 32'h14, 32'h5A5A_5A5A, 4'hF, 1'b0, acc);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid[3] !== 1'b1 && lat < 50);
        if (resp_valid[3] !== 1'b1) timeout_fail("rstr_wait");
        rst[3] = 1'b1;
        @(negedge clk);
        check("rstr_resp_valid", 32'(resp_valid[3]), 32'd0);
        rst[3] = 1'b0;
        txn(3, 1'b0, 32'h14, 32'h0, 4'h0, 0, rd, er, lat, acc);
        check("rstr_mem_written", rd, 32'h5A5A_5A5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
